rsbus_d2r_extractor: RTL and testbench
======================================

# rsbus_d2r_extractor

Ring-side extraction point of the rsbus. Watches the 72-bit ring stream, recognises occupied slots whose header carries this node's ID, and copies the frame into a local word FIFO for the device. On the ring it replaces the frame with an empty slot so downstream injectors can reuse it. Frames that cannot fit in the FIFO stay on the ring unchanged and come round again.

## Interface

Clock and reset: one clock; reset is asynchronous and active-high.

**Parameters**
- `NODE_ID`, default `8'h00`: this node's destination ID, compared against header bits [63:56].
- `FF_DEPTH`, default `32`: local FIFO depth in 72-bit words. Power of two, at least 16.

**Ports**
- `clk` in, 1: clock.
- `rst` in, 1: asynchronous reset, active-high.
- `i_sof` in, 1: ring input, marks the header (first) word of a slot.
- `i_bus` in, 72: ring input word.
- `o_sof` out, 1: ring output, `i_sof` delayed by 2 cycles.
- `o_bus` out, 72: ring output word (delayed, with extracted frames blanked).
- `frm_o_stb` out, 1: local output word valid.
- `frm_o_sof` out, 1: local output word is a frame header.
- `frm_o_bus` out, 72: local output word.
- `frm_o_rdy` in, 1: device accepts a word; a transfer happens when `frm_o_stb & frm_o_rdy`.
- `skip_cnt` out, 16: saturating count of frames for this node left on the ring because the FIFO had no room.
- `ff_err` out, 1: sticky FIFO overflow/underflow flag.

## Operation

**Header decode** (on a word with `i_sof=1`):
- Occupied: `i_bus[71]=1`.
- Frame length: 9 words if `i_bus[39]=1` (long), otherwise 2 words (short).
- Match: occupied and `i_bus[63:56]==NODE_ID`.

**Extract decision** is made on the header word only.
- Extract when the header matches and FIFO free space (`FF_DEPTH` minus occupancy) is at least the frame length.
- Header matches but space is short: no extract, and `skip_cnt` increments, saturating at `16'hFFFF`.

**Frame counter**
- Loaded with length−1 on an extracted header.
- Decrements on each following word; while it is non-zero, words belong to the extracted frame.
- Words after the frame end and before the next `i_sof` pass through untouched.
- A new `i_sof` arriving while the counter is non-zero aborts extraction: the counter clears and `ff_err` is set.

**Ring side**
- Extracted header word goes out as 72'h0, so bit 71 is cleared and the slot is free.
- Extracted payload words go out as 72'h0.
- All other words go out unchanged.
- `o_sof` always equals the delayed `i_sof`.

**Local side**
- Every extracted word, header included, is pushed into the FIFO unmodified.
- A sideband bit records sof; header = 1.
- The FIFO pops on `frm_o_stb & frm_o_rdy`.
- Frame words may be delivered with gaps; their order is preserved.

**Space check and simultaneous events**
- Words of one frame are pushed on consecutive cycles, and pops only free space, so a frame accepted by the space check cannot overflow.
- A simultaneous push and pop leaves occupancy unchanged.
- A push when full, or a pop when empty, sets `ff_err`; the push is dropped, or the pop is ignored.

## Timing

- Ring latency is fixed at 2 cycles.
  - Stage s0 registers `i_sof`/`i_bus` and makes the match/space decision.
  - Stage s1 registers the blanked or passed word onto `o_sof`/`o_bus`.
- FIFO push occurs in s0, at the same cycle as the decision.
- `frm_o_stb` rises no earlier than 1 cycle after the push, because the FIFO output is registered.
- The first header word reaches `frm_o_bus` 2 cycles after it is on `i_bus`, when the FIFO was empty.
- Reset values:
  - `o_sof` = 0, `o_bus` = 0
  - `frm_o_stb` = 0, `frm_o_sof` = 0
  - `skip_cnt` = 0, `ff_err` = 0
  - FIFO empty, frame counter 0
- `frm_o_bus` data bits may be left unreset.
- Reset mid-frame discards any partial frame in the FIFO and in the pipeline.
- After reset release, extraction only starts at the next `i_sof`.

## Test plan

- **Short frame to this node:** `NODE_ID=8'h05`, header `i_bus[71]=1`, `[63:56]=8'h05`, `[39]=0`, plus 1 payload word.
  - `o_bus` is 0 for 2 words, 2 cycles later.
  - With `frm_o_rdy=1`, `frm_o_sof`=1 and then 0, with both words bit-exact.
- **Long frame:** `[39]=1`.
  - 9 words extracted, 9 zero words on the ring.
  - FIFO occupancy goes 0→9.
- **Non-matching frame and empty slots:** destination `8'h06`, plus a header with `[71]=0`.
  - `o_bus` equals `i_bus` delayed by 2 cycles.
  - No `frm_o_stb`.
- **Backpressure:** hold `frm_o_rdy=0` and send 4 long frames to this node.
  - First 3 extracted (27 words).
  - 4th passes through unchanged and `skip_cnt`=1.
  - Release `frm_o_rdy`: 27 words drain in order.
- **Push/pop collision:** with occupancy 10, extract a short frame while `frm_o_rdy=1`.
  - Occupancy returns to 10 after the frame.
  - `ff_err` stays 0.
- **Early sof and reset:**
  - `i_sof` on word 4 of a long extracted frame → `ff_err`=1, sticky.
  - Assert `rst` mid-frame → all outputs 0 and FIFO empty.
  - Next matching frame is extracted correctly.

Source files
------------

// File: rtl/rsbus_d2r_extractor.sv
// rtl/rsbus_d2r_extractor.sv - rsbus ring-side extraction point with local word FIFO
//
// Purpose: watches the 72-bit ring stream, copies occupied frames addressed to
// NODE_ID into a local FIFO and blanks them on the ring so the slot can be
// reused downstream. Frames that do not fit stay on the ring and are counted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_sof, i_bus        ring input (sof marks the slot header word)
//   o_sof, o_bus        ring output, 2 cycles behind the input, extracted words zeroed
//   frm_o_stb/sof/bus   local word output (sof = frame header), registered
//   frm_o_rdy           device accepts the local word when frm_o_stb is high
//   skip_cnt            saturating count of matching frames left on the ring
//   ff_err              sticky flag: FIFO overflow or frame cut short by a new sof
module rsbus_d2r_extractor #(
  parameter logic [7:0] NODE_ID  = 8'h00,
  parameter int         FF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sof,
  input  logic [71:0] i_bus,
  output logic        o_sof,
  output logic [71:0] o_bus,
  output logic        frm_o_stb,
  output logic        frm_o_sof,
  output logic [71:0] frm_o_bus,
  input  logic        frm_o_rdy,
  output logic [15:0] skip_cnt,
  output logic        ff_err
);
  localparam int AW = $clog2(FF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FF_DEPTH);

  // Ring pipeline: s0 holds the input word and its extract flag, s1 drives the ring.
  logic        s0_sof_q;
  logic [71:0] s0_bus_q;
  logic        s0_ext_q;
  logic        o_sof_q;
  logic [71:0] o_bus_q;

  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] skip_q, skip_d;
  logic        err_q, err_d;

  // FIFO: storage array plus one registered output word. Occupancy counts both.
  logic [72:0]   mem_q [FF_DEPTH];
  logic [CW-1:0] wr_ptr_q, rd_ptr_q;
  logic          out_vld_q;
  logic          out_sof_q;
  logic [71:0]   out_bus_q;

  logic [3:0]    frm_len;
  logic          hdr_match;
  logic [CW-1:0] mem_cnt, occ, free_sp;
  logic          has_room, in_frame, ext_hdr, ext, push_ok, pop, load;

  assign frm_len   = i_bus[39] ? 4'd9 : 4'd2;
  assign hdr_match = i_sof & i_bus[71] & (i_bus[63:56] == NODE_ID);
  assign mem_cnt   = wr_ptr_q - rd_ptr_q;
  assign occ       = mem_cnt + {{AW{1'b0}}, out_vld_q};
  assign free_sp   = DEPTH_C - occ;
  assign has_room  = free_sp >= {{(CW-4){1'b0}}, frm_len};
  assign in_frame  = fcnt_q != 4'd0;
  assign ext_hdr   = hdr_match & has_room;
  // A header is judged on its own; a non-header word only follows an accepted frame.
  assign ext       = i_sof ? ext_hdr : in_frame;
  assign push_ok   = ext & (occ != DEPTH_C);
  assign pop       = out_vld_q & frm_o_rdy;
  // Refill the output word whenever it is empty or being consumed this cycle.
  assign load      = (mem_cnt != {CW{1'b0}}) & (~out_vld_q | pop);

  always_comb begin
    fcnt_d = fcnt_q;
    skip_d = skip_q;
    err_d  = err_q;
    if (i_sof) begin
      fcnt_d = ext_hdr ? frm_len - 4'd1 : 4'd0;
      if (in_frame) err_d = 1'b1;
      if (hdr_match && !has_room && skip_q != 16'hFFFF) skip_d = skip_q + 16'd1;
    end else if (in_frame) begin
      fcnt_d = fcnt_q - 4'd1;
    end
    if (ext && !push_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_sof_q <= 1'b0;
      s0_bus_q <= 72'h0;
      s0_ext_q <= 1'b0;
      o_sof_q  <= 1'b0;
      o_bus_q  <= 72'h0;
      fcnt_q   <= 4'd0;
      skip_q   <= 16'h0;
      err_q    <= 1'b0;
    end else begin
      s0_sof_q <= i_sof;
      s0_bus_q <= i_bus;
      s0_ext_q <= ext;
      o_sof_q  <= s0_sof_q;
      o_bus_q  <= s0_ext_q ? 72'h0 : s0_bus_q;
      fcnt_q   <= fcnt_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {i_sof, i_bus};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= {CW{1'b0}};
      rd_ptr_q  <= {CW{1'b0}};
      out_vld_q <= 1'b0;
      out_sof_q <= 1'b0;
      out_bus_q <= 72'h0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (load) begin
        out_vld_q <= 1'b1;
        out_sof_q <= mem_q[rd_ptr_q[AW-1:0]][72];
        out_bus_q <= mem_q[rd_ptr_q[AW-1:0]][71:0];
        rd_ptr_q  <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else if (pop) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign o_sof     = o_sof_q;
  assign o_bus     = o_bus_q;
  assign frm_o_stb = out_vld_q;
  assign frm_o_sof = out_sof_q;
  assign frm_o_bus = out_bus_q;
  assign skip_cnt  = skip_q;
  assign ff_err    = err_q;
endmodule

// File: tb/tb_rsbus_d2r_extractor.sv
// tb/tb_rsbus_d2r_extractor.sv - self-checking bench for rsbus_d2r_extractor
module tb_rsbus_d2r_extractor;
  localparam logic [7:0] NID = 8'h05;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_sof = 1'b0;
  logic [71:0] i_bus = 72'h0;
  logic        frm_o_rdy = 1'b0;
  logic        o_sof;
  logic [71:0] o_bus;
  logic        frm_o_stb, frm_o_sof;
  logic [71:0] frm_o_bus;
  logic [15:0] skip_cnt;
  logic        ff_err;

  rsbus_d2r_extractor #(.NODE_ID(NID), .FF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_sof(i_sof), .i_bus(i_bus),
    .o_sof(o_sof), .o_bus(o_bus),
    .frm_o_stb(frm_o_stb), .frm_o_sof(frm_o_sof), .frm_o_bus(frm_o_bus),
    .frm_o_rdy(frm_o_rdy), .skip_cnt(skip_cnt), .ff_err(ff_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic sof; logic [71:0] bus; int cyc; } word_t;
  word_t       fq[$];
  logic        rs_sof [16];
  logic [71:0] rs_bus [16];
  int          n = 0, left = 0, m_skip = 0;
  logic        m_err = 1'b0;
  logic        e_osof = 1'b0, e_stb = 1'b0, e_fsof = 1'b0, e_err = 1'b0;
  logic [71:0] e_obus = 72'h0, e_fbus = 72'h0;
  logic [15:0] e_skip = 16'h0;
  bit          armed = 1'b0;
  int          checks = 0, passed = 0, stb_seen = 0, rdy_mode = 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, n);
  endtask

  // Reference: frame-level view of the ring. One call per clock cycle, before the edge.
  task automatic model_step(input logic s, input logic [71:0] b, input logic r, input bit in_rst);
    int sz, len;
    bit ext;
    word_t w;
    if (in_rst) begin
      e_osof = 0; e_obus = '0; e_stb = 0; e_fsof = 0; e_fbus = '0; e_skip = '0; e_err = 0;
      fq.delete(); left = 0; m_skip = 0; m_err = 0;
      for (int k = 0; k < 3; k++) begin rs_sof[(n+k)%16] = 0; rs_bus[(n+k)%16] = '0; end
      n++;
      return;
    end
    e_osof = rs_sof[n%16];
    e_obus = rs_bus[n%16];
    e_stb  = (fq.size() > 0) && (fq[0].cyc + 2 <= n);
    e_fsof = 0; e_fbus = '0;
    if (e_stb) begin e_fsof = fq[0].sof; e_fbus = fq[0].bus; end
    e_skip = 16'(m_skip);
    e_err  = m_err;
    sz = fq.size();
    ext = 0;
    if (s) begin
      if (left > 0) m_err = 1;
      left = 0;
      if (b[71] && b[63:56] == NID) begin
        len = b[39] ? 9 : 2;
        if (DEPTH - sz >= len) begin ext = 1; left = len - 1; end
        else if (m_skip < 65535) m_skip++;
      end
    end else if (left > 0) begin
      ext = 1; left--;
    end
    if (ext) begin
      if (sz == DEPTH) m_err = 1;
      else begin w.sof = s; w.bus = b; w.cyc = n; fq.push_back(w); end
    end
    if (e_stb && r) void'(fq.pop_front());
    rs_sof[(n+2)%16] = s;
    rs_bus[(n+2)%16] = ext ? 72'h0 : b;
    n++;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("o_sof", 72'(o_sof), 72'(e_osof));
      chk("o_bus", o_bus, e_obus);
      chk("frm_o_stb", 72'(frm_o_stb), 72'(e_stb));
      if (e_stb) begin
        chk("frm_o_sof", 72'(frm_o_sof), 72'(e_fsof));
        chk("frm_o_bus", frm_o_bus, e_fbus);
      end
      chk("skip_cnt", 72'(skip_cnt), 72'(e_skip));
      chk("ff_err", 72'(ff_err), 72'(e_err));
      if (frm_o_stb) stb_seen++;
    end
  end

  function automatic logic [71:0] rnd72();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [71:0] mkhdr(bit occ, logic [7:0] dst, bit lng);
    logic [71:0] h;
    h = rnd72();
    h[71] = occ; h[63:56] = dst; h[39] = lng;
    return h;
  endfunction

  function automatic logic get_rdy();
    case (rdy_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ($urandom % 4) != 0;
      default: return ($urandom % 8) == 0;
    endcase
  endfunction

  task automatic cyc(input logic s, input logic [71:0] b, input logic r);
    @(posedge clk); #1;
    rst = 0; i_sof = s; i_bus = b; frm_o_rdy = r;
    model_step(s, b, r, 0);
    armed = 1;
  endtask

  task automatic rst_cyc();
    @(posedge clk); #1;
    rst = 1; i_sof = 0; i_bus = '0; frm_o_rdy = 0;
    model_step(0, '0, 0, 1);
    armed = 1;
  endtask

  task automatic send(input logic [71:0] h, input int nw);
    cyc(1, h, get_rdy());
    for (int i = 1; i < nw; i++) cyc(0, rnd72(), get_rdy());
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, rnd72(), get_rdy());
  endtask

  task automatic drain_count(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      cyc(0, rnd72(), 1);
      @(negedge clk);
      if (frm_o_stb) cnt++;
    end
  endtask

  task automatic short_check(input string tag);
    logic [71:0] h, p;
    h = mkhdr(1, NID, 0); p = rnd72();
    cyc(1, h, 1); cyc(0, p, 1); cyc(0, rnd72(), 1);
    @(negedge clk);
    chk({tag, "_ring_hdr"}, o_bus, 72'h0);
    chk({tag, "_stb"}, 72'(frm_o_stb), 72'd1);
    chk({tag, "_sof_hdr"}, 72'(frm_o_sof), 72'd1);
    chk({tag, "_bus_hdr"}, frm_o_bus, h);
    cyc(0, rnd72(), 1);
    @(negedge clk);
    chk({tag, "_ring_pay"}, o_bus, 72'h0);
    chk({tag, "_sof_pay"}, 72'(frm_o_sof), 72'd0);
    chk({tag, "_bus_pay"}, frm_o_bus, p);
  endtask

  initial begin
    int cnt, zeros, s0, kind, nw, len;
    rst_cyc(); rst_cyc();
    @(negedge clk);
    chk("rst_o_sof", 72'(o_sof), 72'd0);
    chk("rst_o_bus", o_bus, 72'h0);
    chk("rst_stb", 72'(frm_o_stb), 72'd0);
    chk("rst_skip", 72'(skip_cnt), 72'd0);
    chk("rst_err", 72'(ff_err), 72'd0);

    short_check("short");
    idle(3);

    // Long frame with the device stalled: 9 blanked ring words, 9 queued words.
    zeros = 0;
    for (int j = 0; j < 11; j++) begin
      if (j == 0) cyc(1, mkhdr(1, NID, 1), 0); else cyc(0, rnd72(), 0);
      @(negedge clk);
      if (j >= 2 && o_bus == 72'h0) zeros++;
    end
    chk("long_ring_zeros", 72'(zeros), 72'd9);
    drain_count(15, cnt);
    chk("long_drained", 72'(cnt), 72'd9);

    rdy_mode = 1;
    s0 = stb_seen;
    send(mkhdr(1, 8'h06, 1), 9);
    send(mkhdr(0, NID, 0), 2);
    send(mkhdr(0, NID, 1), 9);
    idle(4);
    chk("nomatch_no_stb", 72'(stb_seen - s0), 72'd0);

    rdy_mode = 0;
    for (int f = 0; f < 4; f++) send(mkhdr(1, NID, 1), 9);
    idle(2);
    @(negedge clk);
    chk("bp_skip", 72'(skip_cnt), 72'd1);
    drain_count(35, cnt);
    chk("bp_drained", 72'(cnt), 72'd27);

    // Occupancy 10, then a short frame while the device pops two words.
    rdy_mode = 0;
    for (int f = 0; f < 5; f++) send(mkhdr(1, NID, 0), 2);
    idle(1);
    rdy_mode = 1; send(mkhdr(1, NID, 0), 2);
    rdy_mode = 0; idle(3);
    @(negedge clk);
    chk("coll_err", 72'(ff_err), 72'd0);
    drain_count(20, cnt);
    chk("coll_drained", 72'(cnt), 72'd10);

    // New sof on the 4th word of an extracted long frame.
    rdy_mode = 1;
    cyc(1, mkhdr(1, NID, 1), 1); cyc(0, rnd72(), 1); cyc(0, rnd72(), 1);
    cyc(1, mkhdr(0, 8'h00, 0), 1); cyc(0, rnd72(), 1);
    idle(2);
    @(negedge clk);
    chk("abort_err", 72'(ff_err), 72'd1);
    idle(5);
    @(negedge clk);
    chk("abort_err_sticky", 72'(ff_err), 72'd1);

    rdy_mode = 0;
    cyc(1, mkhdr(1, NID, 1), 0); cyc(0, rnd72(), 0); cyc(0, rnd72(), 0); cyc(0, rnd72(), 0);
    rst_cyc();
    @(negedge clk);
    chk("midrst_o_sof", 72'(o_sof), 72'd0);
    chk("midrst_o_bus", o_bus, 72'h0);
    chk("midrst_stb", 72'(frm_o_stb), 72'd0);
    chk("midrst_fsof", 72'(frm_o_sof), 72'd0);
    chk("midrst_fbus", frm_o_bus, 72'h0);
    chk("midrst_skip", 72'(skip_cnt), 72'd0);
    chk("midrst_err", 72'(ff_err), 72'd0);
    rst_cyc();
    short_check("post_rst");
    idle(3);

    // Randomized ring traffic with varying device backpressure.
    for (int sl = 0; sl < 260; sl++) begin
      rdy_mode = ($urandom % 3 == 0) ? 3 : 2;
      kind = $urandom % 5;
      case (kind)
        0: begin len = ($urandom % 2) ? 9 : 2; send(mkhdr(0, NID, len == 9), len); end
        1: send(mkhdr(1, NID, 0), 2);
        2: begin
             nw = ($urandom % 12 == 0) ? $urandom_range(1, 8) : 9;
             send(mkhdr(1, NID, 1), nw);
           end
        3: send(mkhdr(1, 8'($urandom_range(6, 255)), $urandom % 2), 2);
        default: send(mkhdr(1, NID, $urandom % 2), ($urandom % 2) ? 9 : 2);
      endcase
      idle($urandom % 3);
    end
    rdy_mode = 1;
    idle(60);
    chk("final_fifo_empty", 72'(frm_o_stb), 72'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
